// File: rtl/eu_speriph_plug_arbiter_pkg.sv
// Shared types for the event-unit speriph plug arbiter.
// Optional stall counters: EU_PLUG_ARB_STALL_CNT_EN.
package eu_speriph_plug_arbiter_pkg;

  localparam int NB_SPERIPH_PLUGS_EU = 2;
  localparam int EU_ID_WIDTH         = 5;
  localparam int EU_MAX_OUTSTANDING  = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(NB_SPERIPH_PLUGS_EU)-1:0] eu_plug_idx_t;

endpackage

// File: rtl/eu_speriph_plug_arbiter_resp_fifo.sv
// Response-routing FIFO: remembers which plug owns each
// outstanding transaction, in issue order.
module eu_plug_arb_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (!do_push && do_pop) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/eu_speriph_plug_arbiter.sv
// Round-robin merge of speriph plugs onto the event unit port.
// Optional stall counters: EU_PLUG_ARB_STALL_CNT_EN.
module eu_speriph_plug_arbiter
  import eu_speriph_plug_arbiter_pkg::*;
#(
  parameter int NB_PLUGS        = NB_SPERIPH_PLUGS_EU,
  parameter int ID_WIDTH        = EU_ID_WIDTH,
  parameter int MAX_OUTSTANDING = EU_MAX_OUTSTANDING
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_PLUGS-1:0]                plug_req_i,
  input  logic [NB_PLUGS-1:0][31:0]          plug_add_i,
  input  logic [NB_PLUGS-1:0]                plug_wen_i,
  input  logic [NB_PLUGS-1:0][31:0]          plug_wdata_i,
  input  logic [NB_PLUGS-1:0][3:0]           plug_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_id_i,
  output logic [NB_PLUGS-1:0]                plug_gnt_o,
  output logic [NB_PLUGS-1:0]                plug_r_valid_o,
  output logic                               plug_r_opc_o,
  output logic [ID_WIDTH-1:0]                plug_r_id_o,
  output logic [31:0]                        plug_r_rdata_o,
  output logic                               eu_req_o,
  output logic [31:0]                        eu_add_o,
  output logic                               eu_wen_o,
  output logic [31:0]                        eu_wdata_o,
  output logic [3:0]                         eu_be_o,
  output logic [ID_WIDTH-1:0]                eu_id_o,
  input  logic                               eu_gnt_i,
  input  logic                               eu_r_valid_i,
  input  logic                               eu_r_opc_i,
  input  logic [ID_WIDTH-1:0]                eu_r_id_i,
  input  logic [31:0]                        eu_r_rdata_i,
  output logic                               resp_err_o,
  output logic [NB_PLUGS-1:0][15:0]          stall_cnt_o,
  input  logic                               stall_clr_i
);

  localparam int IW = idx_width(NB_PLUGS);

  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       winner;
  logic [IW-1:0]       fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                req_int;
  logic                push;
  logic                pop;
  logic                resp_err_q;
  logic [NB_PLUGS-1:0] gnt;
  logic [NB_PLUGS-1:0] r_valid;

  always_comb begin
    logic       found;
    logic [IW-1:0] kk;
    winner = '0;
    found  = 1'b0;
    kk     = '0;
    for (int i = 0; i < NB_PLUGS; i++) begin
      kk = IW'((int'(rr_ptr) + i) % NB_PLUGS);
      if (!found && plug_req_i[kk]) begin
        winner = kk;
        found  = 1'b1;
      end
    end
  end

  // No full bypass: a pop this cycle does not reopen the port until next cycle.
  assign req_int = (|plug_req_i) & ~fifo_full;
  assign push    = req_int & eu_gnt_i;
  assign pop     = eu_r_valid_i & ~fifo_empty;

  eu_plug_arb_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IW)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (winner),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (winner == IW'(NB_PLUGS - 1)) ? '0 : winner + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_err_q <= 1'b0;
    end else if (eu_r_valid_i && fifo_empty) begin
      resp_err_q <= 1'b1;
    end
  end

  always_comb begin
    gnt     = '0;
    r_valid = '0;
    if (push && !rst_i) begin
      gnt[winner] = 1'b1;
    end
    if (pop && !rst_i) begin
      r_valid[fifo_head] = 1'b1;
    end
  end

  assign plug_gnt_o     = gnt;
  assign plug_r_valid_o = r_valid;
  assign plug_r_opc_o   = eu_r_opc_i & ~rst_i;
  assign plug_r_id_o    = rst_i ? '0 : eu_r_id_i;
  assign plug_r_rdata_o = rst_i ? '0 : eu_r_rdata_i;
  assign eu_req_o       = req_int & ~rst_i;
  assign eu_add_o       = rst_i ? '0 : plug_add_i[winner];
  assign eu_wen_o       = plug_wen_i[winner] & ~rst_i;
  assign eu_wdata_o     = rst_i ? '0 : plug_wdata_i[winner];
  assign eu_be_o        = rst_i ? '0 : plug_be_i[winner];
  assign eu_id_o        = rst_i ? '0 : plug_id_i[winner];
  assign resp_err_o     = resp_err_q & ~rst_i;

`ifdef EU_PLUG_ARB_STALL_CNT_EN
  logic [NB_PLUGS-1:0][15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || stall_clr_i) begin
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NB_PLUGS; i++) begin
        if (plug_req_i[i] && !gnt[i] && stall_q[i] != 16'hffff) begin
          stall_q[i] <= stall_q[i] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = rst_i ? '0 : stall_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr_i;
  assign stall_cnt_o      = '0;
`endif

endmodule
